irq_conditioner: RTL
====================

IRQ_CONDITIONER -- requirements
Module: irq_conditioner

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  one clock; reset is synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-003 i_irq_raw  in  31  asynchronous external interrupt lines, bit n = source n.
REQ-004 i_regaddr  in  2  register select: 0 MODE, 1 POL, 2 PEND, 3 MASK.
REQ-005 i_we  in  1  register write strobe, one write per cycle with i_we=1.
REQ-006 i_wdata  in  31  write data.
REQ-007 o_rdata  out  31  registered read data of the register at i_regaddr, valid 1 cycle after the address.
REQ-008 o_ext  out  31  conditioned requests; connects directly to the interrupt controller's i_ext.

Function
REQ-009 Each line SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-010 Active level SHALL be act(x) = x XOR POL[n]; changing POL SHALL NOT create an edge, because both samples use the current POL.
REQ-011 MODE[n]=1 (edge): PEND[n] SHALL set when act(s2)=1 and act(s3)=0, and SHALL stay sticky until cleared.
REQ-012 MODE[n]=0 (level): PEND[n] SHALL load act(s2) every cycle; writes to PEND SHALL have no effect on that bit.
REQ-013 A write to PEND SHALL be write-1-to-clear; if a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-014 MODE, POL and MASK writes SHALL take effect at the edge of the write; the next cycle's detection SHALL use the new values.
REQ-015 o_ext SHALL be registered as PEND & ~MASK; masked lines SHALL still latch PEND.
REQ-016 Unmasking an already-pending line SHALL assert o_ext[n] 1 cycle after the MASK write edge.
REQ-017 Latency: raw line active before edge k SHALL give s1 at k, s2 at k+1, PEND at k+2, and o_ext high after edge k+3.
REQ-018 Bits are independent; any number of lines SHALL be able to set or clear in the same cycle.
REQ-019 Reading PEND SHALL NOT clear it.

Reset
REQ-020 When rst=0 at an edge, the following SHALL be 0: s1, s2, s3, filter state, MODE, POL, PEND, o_ext and o_rdata.
REQ-021 When rst=0 at an edge, MASK SHALL be all ones (all lines masked).
REQ-022 Reset asserted mid-operation SHALL discard pending and in-flight edges.
REQ-023 After rst returns to 1, a line already held active SHALL be detected only in level mode; in edge mode it needs a fresh transition.

Configuration
REQ-024 With macro IRQ_DEBOUNCE_EN defined, each line SHALL add history flops h1..h3 after s2 and a filtered value filt.
REQ-025 filt SHALL update only when s2, h1, h2 and h3 are equal.
REQ-026 Detection SHALL then use filt/filt_d in place of s2/s3, giving o_ext high after edge k+7.
REQ-027 With IRQ_DEBOUNCE_EN defined, an active pulse present for fewer than 4 consecutive sampling edges SHALL never set PEND.
REQ-028 Without IRQ_DEBOUNCE_EN, none of the REQ-024 to REQ-027 logic SHALL exist and REQ-017 latency SHALL apply.

Verification
REQ-029 Reset, then read MASK -> o_rdata=0x7FFFFFFF; read MODE, POL and PEND -> 0; o_ext=0.
REQ-030 MASK=0, MODE[1]=1, raise i_irq_raw[1] before edge k -> o_ext=0x00000002 after edge k+3; it stays after the raw line drops; writing PEND=0x2 -> o_ext=0 next cycle.
REQ-031 Level mode, POL[0]=1, MASK=0, i_irq_raw[0]=0 held -> o_ext[0]=1 after 3 edges; raising raw[0] -> o_ext[0]=0 3 cycles later; writing PEND=0x1 has no effect.
REQ-032 Edge mode on line 2, raw held high, assert W1C PEND=0x4 in the same cycle a new edge sets PEND[2] -> PEND[2] remains 1.
REQ-033 MASK=0x7FFFFFFF, fire edge on line 30 -> PEND=0x40000000, o_ext=0; write MASK=0 -> o_ext=0x40000000 next cycle.
REQ-034 With IRQ_DEBOUNCE_EN defined, edge mode: a 3-cycle pulse on line 5 -> PEND stays 0; a 4-cycle pulse -> o_ext[5]=1 after edge k+7.

Source files
------------

// File: rtl/irq_conditioner.sv
// Interrupt line conditioner: synchronizes 31 raw lines, applies polarity, edge/level
// detection into a sticky/level PEND register, and masks onto o_ext.
// Optional macro IRQ_DEBOUNCE_EN inserts a 4-sample agreement filter ahead of detection.
module irq_conditioner (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:0] i_irq_raw,
    input  logic [1:0]  i_regaddr,
    input  logic        i_we,
    input  logic [30:0] i_wdata,
    output logic [30:0] o_rdata,
    output logic [30:0] o_ext
);

    localparam logic [1:0] ADDR_MODE = 2'd0;
    localparam logic [1:0] ADDR_POL  = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_MASK = 2'd3;

    logic [30:0] s1_q, s1_d;
    logic [30:0] s2_q, s2_d;
    logic [30:0] mode_q, mode_d;
    logic [30:0] pol_q, pol_d;
    logic [30:0] pend_q, pend_d;
    logic [30:0] mask_q, mask_d;
    logic [30:0] ext_q, ext_d;
    logic [30:0] rdata_q, rdata_d;

    logic [30:0] det_cur, det_prev;
    logic [30:0] act_cur, act_prev;
    logic [30:0] edge_set, pend_clr;

`ifdef IRQ_DEBOUNCE_EN
    logic [30:0] h1_q, h1_d;
    logic [30:0] h2_q, h2_d;
    logic [30:0] h3_q, h3_d;
    logic [30:0] filt_q, filt_d;
    logic [30:0] filt_dly_q, filt_dly_d;
    logic [30:0] stable;
`else
    logic [30:0] s3_q, s3_d;
`endif

    always_comb begin
        s1_d = i_irq_raw;
        s2_d = s1_q;
`ifdef IRQ_DEBOUNCE_EN
        h1_d = s2_q;
        h2_d = h1_q;
        h3_d = h2_q;
        // filt only follows s2 once four consecutive samples agree
        stable     = ~(s2_q ^ h1_q) & ~(h1_q ^ h2_q) & ~(h2_q ^ h3_q);
        filt_d     = (stable & s2_q) | (~stable & filt_q);
        filt_dly_d = filt_q;
        det_cur    = filt_q;
        det_prev   = filt_dly_q;
`else
        s3_d     = s2_q;
        det_cur  = s2_q;
        det_prev = s3_q;
`endif
        // Both samples use the current POL, so a POL change alone never forms an edge
        act_cur  = det_cur ^ pol_q;
        act_prev = det_prev ^ pol_q;
        edge_set = mode_q & act_cur & ~act_prev;
        pend_clr = (i_we && i_regaddr == ADDR_PEND) ? i_wdata : 31'h0;

        // Edge bits: sticky with W1C, set wins. Level bits: follow the active level.
        pend_d = (mode_q & ((pend_q & ~pend_clr) | edge_set)) | (~mode_q & act_cur);

        mode_d = (i_we && i_regaddr == ADDR_MODE) ? i_wdata : mode_q;
        pol_d  = (i_we && i_regaddr == ADDR_POL)  ? i_wdata : pol_q;
        mask_d = (i_we && i_regaddr == ADDR_MASK) ? i_wdata : mask_q;

        ext_d = pend_q & ~mask_q;

        case (i_regaddr)
            ADDR_MODE: rdata_d = mode_q;
            ADDR_POL:  rdata_d = pol_q;
            ADDR_PEND: rdata_d = pend_q;
            default:   rdata_d = mask_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            ext_q   <= '0;
            rdata_q <= '0;
`ifdef IRQ_DEBOUNCE_EN
            h1_q       <= '0;
            h2_q       <= '0;
            h3_q       <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
`else
            s3_q <= '0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ext_q   <= ext_d;
            rdata_q <= rdata_d;
`ifdef IRQ_DEBOUNCE_EN
            h1_q       <= h1_d;
            h2_q       <= h2_d;
            h3_q       <= h3_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
`else
            s3_q <= s3_d;
`endif
        end
    end

    assign o_rdata = rdata_q;
    assign o_ext   = ext_q;

endmodule
